// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the program counter, registers the fetched word into ID,
// tracks ID/EXE PCs and handles redirects, hazard stalls and the EXEC detour.
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_sel,
    input  logic        pc_bj_rf,
    input  logic        pc_br_jmp,
    input  logic        pc_run,
    input  logic [7:0]  br_off,
    input  logic [11:0] jmp_off,
    input  logic [15:0] rf_target,
    input  logic [15:0] imem_data,
    output logic [15:0] imem_addr,
    output logic [15:0] pc,
    output logic [15:0] instr_id,
    output logic [15:0] pc_id,
    output logic [15:0] pc_ex,
    output logic [15:0] link_pc,
    output logic        exec_busy
);

    // state      | meaning
    // RUN        | normal fetch: advance, redirect, hold or EXEC entry
    // EXEC_FETCH | detour word at rf_target is being fetched; next PC is ret_pc
    typedef enum logic {RUN, EXEC_FETCH} state_t;

    state_t      state, state_next;
    logic [15:0] ret_pc, ret_pc_next;
    logic [15:0] pc_next, instr_id_next, pc_id_next, pc_ex_next;
    logic [15:0] target;
    logic        exec_entry;

    assign imem_addr  = pc;
    assign link_pc    = pc_ex + 16'd1;
    assign exec_busy  = (state == EXEC_FETCH);
    assign exec_entry = (state == RUN) && pc_sel && pc_bj_rf && !pc_run;

    always_comb begin
        if (pc_bj_rf)
            target = rf_target;
        else if (pc_br_jmp)
            target = pc_ex + 16'd1 + {{4{jmp_off[11]}}, jmp_off};
        else
            target = pc_ex + 16'd1 + {{8{br_off[7]}}, br_off};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            instr_id <= NOP_WORD;
            pc_id    <= 16'h0000;
            pc_ex    <= 16'h0000;
            ret_pc   <= 16'h0000;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            instr_id <= instr_id_next;
            pc_id    <= pc_id_next;
            pc_ex    <= pc_ex_next;
            ret_pc   <= ret_pc_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        instr_id_next = instr_id;
        pc_id_next    = pc_id;
        pc_ex_next    = pc_ex;
        ret_pc_next   = ret_pc;

        if (state == EXEC_FETCH) begin
            instr_id_next = imem_data;
            pc_id_next    = pc;
            pc_next       = ret_pc;
            pc_ex_next    = pc_id;
            state_next    = RUN;
        end else if (exec_entry) begin
            // pc_id is left alone: the NOP now in ID carries the stale PC
            ret_pc_next   = pc;
            pc_next       = rf_target;
            instr_id_next = NOP_WORD;
            pc_ex_next    = pc_id;
            state_next    = EXEC_FETCH;
        end else if (pc_sel && pc_run) begin
            pc_next       = target;
            instr_id_next = NOP_WORD;
            pc_id_next    = 16'h0000;
            pc_ex_next    = pc_id;
        end else if (pc_run) begin
            pc_next       = pc + 16'd1;
            instr_id_next = imem_data;
            pc_id_next    = pc;
            pc_ex_next    = pc_id;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios then randomized
// select traffic, all compared against a cycle-level behavioural model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, pc_sel, pc_bj_rf, pc_br_jmp, pc_run;
    logic [7:0]  br_off;
    logic [11:0] jmp_off;
    logic [15:0] rf_target, imem_data, imem_addr, pc, instr_id, pc_id, pc_ex, link_pc;
    logic        exec_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // model of the architectural state
    logic [15:0] m_pc, m_instr, m_pc_id, m_pc_ex, m_ret;
    bit          m_detour;

    always #5 clk = ~clk;

    assign imem_data = 16'hA000 + imem_addr;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .pc_sel(pc_sel), .pc_bj_rf(pc_bj_rf),
        .pc_br_jmp(pc_br_jmp), .pc_run(pc_run), .br_off(br_off),
        .jmp_off(jmp_off), .rf_target(rf_target), .imem_data(imem_data),
        .imem_addr(imem_addr), .pc(pc), .instr_id(instr_id), .pc_id(pc_id),
        .pc_ex(pc_ex), .link_pc(link_pc), .exec_busy(exec_busy)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    // one clock: apply inputs, advance model per the priority rules, compare everything
    task automatic cyc(input bit r, input bit sel, input bit bjrf, input bit brjmp,
                       input bit run, input logic [7:0] br, input logic [11:0] jmp,
                       input logic [15:0] rft);
        int off;
        logic [15:0] tgt;
        rst = r; pc_sel = sel; pc_bj_rf = bjrf; pc_br_jmp = brjmp; pc_run = run;
        br_off = br; jmp_off = jmp; rf_target = rft;
        if (r) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_pc_id = 0; m_pc_ex = 0; m_ret = 0; m_detour = 0;
        end else if (m_detour) begin
            m_instr = mem_word(m_pc); m_pc_ex = m_pc_id; m_pc_id = m_pc; m_pc = m_ret; m_detour = 0;
        end else if (sel && bjrf && !run) begin
            m_ret = m_pc; m_pc = rft; m_instr = 16'h0000; m_pc_ex = m_pc_id; m_detour = 1;
        end else if (sel && run) begin
            if (brjmp) off = (int'(jmp) >= 2048) ? int'(jmp) - 4096 : int'(jmp);
            else       off = (int'(br) >= 128) ? int'(br) - 256 : int'(br);
            tgt = bjrf ? rft : 16'((int'(m_pc_ex) + 1 + off) & 16'hFFFF);
            m_pc = tgt; m_instr = 16'h0000; m_pc_ex = m_pc_id; m_pc_id = 0;
        end else if (run) begin
            m_instr = mem_word(m_pc); m_pc_ex = m_pc_id; m_pc_id = m_pc; m_pc = m_pc + 16'd1;
        end
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("imem_addr", imem_addr, m_pc);
        check("instr_id", instr_id, m_instr);
        check("pc_id", pc_id, m_pc_id);
        check("pc_ex", pc_ex, m_pc_ex);
        check("link_pc", link_pc, m_pc_ex + 16'd1);
        check("exec_busy", {15'd0, exec_busy}, {15'd0, m_detour});
    endtask

    task automatic adv();
        cyc(0, 0, 0, 0, 1, 8'h00, 12'h000, 16'h0000);
    endtask

    task automatic jr(input logic [15:0] t);
        cyc(0, 1, 1, 0, 1, 8'h00, 12'h000, t);
    endtask

    initial begin
        rst = 1; pc_sel = 0; pc_bj_rf = 0; pc_br_jmp = 0; pc_run = 0;
        br_off = 0; jmp_off = 0; rf_target = 0;
        m_pc = 0; m_instr = 0; m_pc_id = 0; m_pc_ex = 0; m_ret = 0; m_detour = 0;

        // reset then free run
        cyc(1, 0, 0, 0, 1, 8'h00, 12'h000, 16'h0000);
        check("rst_pc", pc, 16'h0000);
        check("rst_instr", instr_id, 16'h0000);
        check("rst_busy", {15'd0, exec_busy}, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            adv();
            check("run_instr", instr_id, 16'hA000 + 16'(i));
            check("run_pc_id", pc_id, 16'(i));
        end
        check("run_pc3", pc, 16'h0003);

        // hold two cycles at pc=5
        adv(); adv();
        check("pre_hold_pc", pc, 16'h0005);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 0, 8'h00, 12'h000, 16'h0000);
            check("hold_pc", pc, 16'h0005);
            check("hold_instr", instr_id, 16'hA004);
        end
        adv();
        check("post_hold_instr", instr_id, 16'hA005);
        check("post_hold_pc", pc, 16'h0006);

        // branch with negative offset from pc_ex=0010
        jr(16'h0010); adv(); adv();
        check("br_pc_ex", pc_ex, 16'h0010);
        cyc(0, 1, 0, 0, 1, 8'hFC, 12'h000, 16'h0000);
        check("br_pc", pc, 16'h000D);
        check("br_flush", instr_id, 16'h0000);
        adv();
        check("br_target_instr", instr_id, 16'hA00D);

        // JAL with most-negative 12-bit offset from pc_ex=0900
        jr(16'h0900); adv(); adv();
        check("jal_link", link_pc, 16'h0901);
        cyc(0, 1, 0, 1, 1, 8'h00, 12'h800, 16'h0000);
        check("jal_pc", pc, 16'h0101);
        jr(16'h1234);
        check("jr_pc", pc, 16'h1234);

        // EXEC detour from pc=0020
        jr(16'h0020);
        cyc(0, 1, 1, 0, 0, 8'h00, 12'h000, 16'h0300);
        check("exec1_pc", pc, 16'h0300);
        check("exec1_instr", instr_id, 16'h0000);
        check("exec1_busy", {15'd0, exec_busy}, 16'h0001);
        adv();
        check("exec2_instr", instr_id, 16'hA300);
        check("exec2_pc", pc, 16'h0020);
        check("exec2_busy", {15'd0, exec_busy}, 16'h0000);
        adv();
        check("exec3_instr", instr_id, 16'hA020);

        // wrap and reset mid-EXEC
        jr(16'hFFFF); adv();
        check("wrap_pc", pc, 16'h0000);
        jr(16'h0040);
        cyc(0, 1, 1, 0, 0, 8'h00, 12'h000, 16'h0300);
        cyc(1, 0, 0, 0, 1, 8'h00, 12'h000, 16'h0000);
        check("rst_exec_pc", pc, 16'h0000);
        check("rst_exec_busy", {15'd0, exec_busy}, 16'h0000);
        check("rst_exec_instr", instr_id, 16'h0000);

        // randomized select traffic
        for (int i = 0; i < 400; i++) begin
            int kind;
            kind = int'($urandom_range(0, 19));
            cyc(kind == 0,
                kind inside {[1:7]},
                (kind inside {[1:3]}) || ($urandom_range(0, 3) == 0),
                $urandom_range(0, 1) == 1,
                !(kind inside {2, 3, 8, 9, 10}),
                8'($urandom), 12'($urandom), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Fetch-side counterpart of the pipeline control decoder. Owns the program counter, drives the instruction-memory address, registers the fetched word into the ID stage, and carries the PC of the ID and EXE stage instructions. It consumes the decoder's PC-steering select bits (PC_SEL, PC_BJ_RF, PC_Br_Jmp, PC_HOLD) and turns them into next-PC selection, stalls, flushes and the EXEC one-shot detour.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_WORD, 16'h0000, word injected into ID on flush
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pc_sel  in  1  sel[0]: 0 = sequential PC+1, 1 = redirect
- pc_bj_rf  in  1  sel[1]: 1 = target from register file, 0 = PC-relative
- pc_br_jmp  in  1  sel[2]: 1 = jump (12-bit offset), 0 = branch (8-bit offset); ignored when pc_bj_rf=1
- pc_run  in  1  sel[9]: 1 = PC may advance, 0 = hold PC
- br_off  in  8  branch offset, two's complement, from EXE-stage instruction bits [7:0]
- jmp_off  in  12  jump offset, two's complement, from EXE-stage instruction bits [11:0]
- rf_target  in  16  register-file target for JR/EXEC
- imem_data  in  16  instruction word at imem_addr (combinational memory)
- imem_addr  out  16  equals pc
- pc  out  16  current fetch PC
- instr_id  out  16  instruction in ID (input of the control decoder)
- pc_id  out  16  PC of instr_id
- pc_ex  out  16  PC of the EXE-stage instruction
- link_pc  out  16  pc_ex + 1, return address for JAL (combinational)
- exec_busy  out  1  high while the EXEC detour is in flight

## Operation
- States: RUN, EXEC_FETCH. Reset: state=RUN, pc=RESET_PC, instr_id=NOP_WORD, pc_id=0, pc_ex=0, ret_pc=0, exec_busy=0.
- Per-cycle action, priority highest first:
  - rst: reset values above.
  - EXEC entry: state=RUN and pc_sel=1, pc_bj_rf=1, pc_run=0. Actions: ret_pc<=pc, pc<=rf_target, instr_id<=NOP_WORD, pc_ex<=pc_id, state<=EXEC_FETCH.
  - EXEC_FETCH, regardless of select inputs except rst: instr_id<=imem_data, pc_id<=pc, pc<=ret_pc, pc_ex<=pc_id, state<=RUN. The detour instruction enters ID exactly once; the fetch then resumes at the saved PC.
  - Redirect: pc_sel=1 with pc_run=1. Target selection:
    - pc_bj_rf=1: rf_target (JR).
    - pc_br_jmp=1: pc_ex+1+sext(jmp_off).
    - Otherwise: pc_ex+1+sext(br_off).
    - Actions: pc<=target, instr_id<=NOP_WORD, pc_id<=0, pc_ex<=pc_id.
  - Hold: pc_run=0, not EXEC entry. pc, instr_id, pc_id and pc_ex all keep their values (hazard stall).
  - Advance: pc<=pc+1, instr_id<=imem_data, pc_id<=pc, pc_ex<=pc_id.
- Arithmetic is 16-bit modulo: FFFF+1 = 0000. Offsets are sign-extended to 16 bits before the add. Carries are discarded.
- Redirect with pc_run=0 and pc_bj_rf=0: treated as Hold. The decoder never issues this combination.
- exec_busy = (state==EXEC_FETCH).

## Timing
- imem_addr = pc in the same cycle. Fetch-to-ID latency is 1 clock.
- Redirect decided in cycle t (branch/JAL/JR in EXE):
  - pc = target at t+1.
  - instr_id = NOP_WORD at t+1.
  - Target instruction is in ID at t+2.
  - Penalty: 1 flushed slot.
- EXEC decided in cycle t:
  - pc = rf_target and instr_id = NOP at t+1.
  - Detour instruction in ID and pc = ret_pc at t+2.
  - Instruction at ret_pc in ID at t+3.
- Reset asserted mid-EXEC: returns to RUN at RESET_PC on the next edge. ret_pc is cleared and the detour is abandoned.
- Hold lasting N cycles stretches all of the above by exactly N cycles, with no lost or duplicated fetch.

## Test plan
- Reset then free run, imem[a]=16'hA000+a: after rst, instr_id sequence is 0000, A000, A001, A002. pc_id is 0, 1, 2 one cycle behind. pc reaches 3 on the 4th edge.
- Hold: pc_run=0 for 2 cycles while pc=5. pc stays 5 and instr_id stays A004 for 2 cycles. Next cycle instr_id=A005 and pc=6, with no skip or repeat.
- Branch: pc_ex=0010, br_off=8'hFC, pc_sel=1, pc_br_jmp=0, pc_run=1. Next cycle pc=000D and instr_id=0000. The cycle after, instr_id=A00D.
- JAL/JR: jmp_off=12'h800 with pc_ex=0900 gives pc=0101 and link_pc=0901 during the redirect cycle. Separately, JR with rf_target=1234 gives pc=1234.
- EXEC: pc=0020, rf_target=0300, pc_sel=1, pc_bj_rf=1, pc_run=0.
  - t+1: pc=0300, instr_id=0000, exec_busy=1.
  - t+2: instr_id=A300, pc=0020, exec_busy=0.
  - t+3: instr_id=A020.
- Wrap and reset: pc=FFFF advancing gives pc=0000. Separately, rst asserted during EXEC_FETCH gives pc=RESET_PC, exec_busy=0, instr_id=0000.
